aes_key_sched: RTL and testbench

- Sequential AES-128 key-expansion controller.
- Time-shares one SubWord instance (four S-boxes) to produce the 11 round keys.
- Computes one 32-bit expanded word per clock.
- Streams each 128-bit round key out over a valid/ready handshake to the round datapath.
- Sits between the key register and the cipher round engine.

---
 rtl/aes_key_sched.sv | 153 +++++++++++++++
 tb/tb_aes_key_sched.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_key_sched.sv
// AES-128 key-expansion controller. One SubWord (four S-boxes) is time-shared
// to produce one expanded 32-bit word per clock. Each 128-bit round key is
// offered to the round datapath over a valid/ready handshake.
module aes_key_sched #(
  parameter int BYTE     = 8,
  parameter int WORD     = 32,
  parameter int SENTENCE = 128,
  parameter int ROUNDS   = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [SENTENCE-1:0] key_in,
  output logic                busy,
  output logic                rk_valid,
  input  logic                rk_ready,
  output logic [SENTENCE-1:0] round_key,
  output logic [3:0]          round_idx,
  output logic                done
);

  typedef enum logic [1:0] {
    IDLE,
    OUT,
    EXPAND
  } state_t;

  state_t              state;
  logic [SENTENCE-1:0] win;      // word window {w_oldest .. w_newest}
  logic [1:0]          k;        // word counter inside EXPAND
  logic [BYTE-1:0]     rcon;

  logic [WORD-1:0]     w_newest;
  logic [WORD-1:0]     w_oldest;
  logic [WORD-1:0]     rot_word;
  logic [WORD-1:0]     sub_word;
  logic [WORD-1:0]     temp;
  logic [WORD-1:0]     new_word;

  // GF(2^8) multiply modulo x^8+x^4+x^3+x+1
  function automatic logic [BYTE-1:0] gmul(input logic [BYTE-1:0] a,
                                           input logic [BYTE-1:0] b);
    logic [BYTE-1:0] p;
    logic [BYTE-1:0] aa;
    logic [BYTE-1:0] bb;
    p  = '0;
    aa = a;
    bb = b;
    for (int unsigned i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = {1'b0, bb[7:1]};
    end
    return p;
  endfunction

  // S-box computed as multiplicative inverse (x^254, 0 -> 0) plus affine map
  function automatic logic [BYTE-1:0] sbox(input logic [BYTE-1:0] x);
    logic [BYTE-1:0] sq;
    logic [BYTE-1:0] inv;
    sq  = x;
    inv = 8'h01;
    for (int unsigned i = 1; i < 8; i++) begin
      sq  = gmul(sq, sq);
      inv = gmul(inv, sq);
    end
    return inv
         ^ {inv[6:0], inv[7]}
         ^ {inv[5:0], inv[7:6]}
         ^ {inv[4:0], inv[7:5]}
         ^ {inv[3:0], inv[7:4]}
         ^ 8'h63;
  endfunction

  function automatic logic [WORD-1:0] subword(input logic [WORD-1:0] t);
    logic [WORD-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      r[i*BYTE +: BYTE] = sbox(t[i*BYTE +: BYTE]);
    end
    return r;
  endfunction

  function automatic logic [BYTE-1:0] xtime(input logic [BYTE-1:0] r);
    return {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
  endfunction

  // Next expansion word; the single SubWord result only matters when k == 0
  always_comb begin
    w_newest = win[WORD-1:0];
    w_oldest = win[SENTENCE-1 -: WORD];
    rot_word = {w_newest[WORD-BYTE-1:0], w_newest[WORD-1 -: BYTE]};
    sub_word = subword(rot_word);
    temp     = (k == 2'd0) ? (sub_word ^ {rcon, {(WORD-BYTE){1'b0}}}) : w_newest;
    new_word = w_oldest ^ temp;
  end

  // Control FSM, word window and registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      win       <= '0;
      round_idx <= '0;
      k         <= '0;
      rcon      <= 8'h01;
      busy      <= 1'b0;
      rk_valid  <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            win       <= key_in;
            round_idx <= '0;
            rcon      <= 8'h01;
            k         <= '0;
            busy      <= 1'b1;
            rk_valid  <= 1'b1;
            state     <= OUT;
          end
        end
        OUT: begin
          if (rk_ready) begin
            rk_valid <= 1'b0;
            k        <= '0;
            if (round_idx == 4'(ROUNDS)) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= IDLE;
            end else begin
              state <= EXPAND;
            end
          end
        end
        EXPAND: begin
          win <= {win[SENTENCE-WORD-1:0], new_word};
          k   <= k + 2'd1;
          if (k == 2'd3) begin
            round_idx <= round_idx + 4'd1;
            rcon      <= xtime(rcon);
            rk_valid  <= 1'b1;
            state     <= OUT;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign round_key = win;

endmodule

// File: tb/tb_aes_key_sched.sv
// Self-checking bench for aes_key_sched: a reference key expansion fills a
// scoreboard on every start; a handshake monitor pops and compares.
module tb_aes_key_sched;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [127:0] key_in;
  logic         busy;
  logic         rk_valid;
  logic         rk_ready;
  logic [127:0] round_key;
  logic [3:0]   round_idx;
  logic         done;

  aes_key_sched #(
    .BYTE(8),
    .WORD(32),
    .SENTENCE(128),
    .ROUNDS(10)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .key_in(key_in),
    .busy(busy),
    .rk_valid(rk_valid),
    .rk_ready(rk_ready),
    .round_key(round_key),
    .round_idx(round_idx),
    .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   idx;
    logic [127:0] key;
  } sb_entry_t;

  sb_entry_t    sb_q[$];
  int           n_vec  = 0;
  int           n_miss = 0;
  logic [7:0]   sb_tab[256];
  logic [127:0] exp_rk[11];
  logic [127:0] seen[11];
  logic [7:0]   rcon_tab[10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // S-box table built by walking generator 3 and its inverse
  function automatic void build_sbox();
    logic [7:0] p;
    logic [7:0] q;
    logic [7:0] x;
    p = 8'h01;
    q = 8'h01;
    for (int n = 0; n < 255; n++) begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sb_tab[p] = x ^ 8'h63;
    end
    sb_tab[0] = 8'h63;
  endfunction

  function automatic void expand(input logic [127:0] key);
    logic [31:0] w[44];
    logic [31:0] t;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb_tab[t[31:24]], sb_tab[t[23:16]], sb_tab[t[15:8]], sb_tab[t[7:0]]};
        t = t ^ {rcon_tab[i/4-1], 24'h0};
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  // Handshake monitor: every accepted round key must match the scoreboard head
  always @(negedge clk) begin
    sb_entry_t e;
    if (rst_n && rk_valid && rk_ready) begin
      if (sb_q.size() == 0) begin
        check("sb_underflow", 128'(round_idx), 128'hff);
      end else begin
        e = sb_q.pop_front();
        check("rk_idx", 128'(round_idx), 128'(e.idx));
        check("rk_key", round_key, e.key);
      end
      seen[round_idx] = round_key;
    end
  end

  // Called at #1 after an edge; start is sampled at the next edge
  task automatic start_key(input logic [127:0] key);
    sb_entry_t e;
    expand(key);
    for (int r = 0; r < 11; r++) begin
      e.idx = 4'(r);
      e.key = exp_rk[r];
      sb_q.push_back(e);
    end
    start  = 1'b1;
    key_in = key;
    @(posedge clk); #1;
    start = 1'b0;
    check("start_valid", 128'(rk_valid), 128'd1);
    check("start_idx", 128'(round_idx), 128'd0);
    check("start_key", round_key, key);
    check("start_busy", 128'(busy), 128'd1);
    check("done_one_cycle", 128'(done), 128'd0);
  endtask

  // Drives rk_ready until done; optional stall at one round and busy-start poke
  task automatic run_exp(input int stall_round, input int stall_len,
                         input bit poke, output int cyc);
    int   since;
    int   stall_left;
    bit   pv;
    bit   phs;
    bit   stalled;
    since      = 0;
    stall_left = stall_len;
    pv         = 1'b1;
    cyc        = 0;
    for (int n = 0; n < 400; n++) begin
      stalled = 1'b0;
      if (rk_valid && (int'(round_idx) == stall_round) && (stall_left > 0)) begin
        rk_ready = 1'b0;
        stall_left--;
        stalled = 1'b1;
      end else begin
        rk_ready = 1'b1;
      end
      if (poke && cyc == 10) begin
        start  = 1'b1;
        key_in = ~key_in;
      end else begin
        start = 1'b0;
      end
      phs = rk_valid && rk_ready;
      @(posedge clk); #1;
      cyc++;
      if (phs) since = 0;
      else     since++;
      if (rk_valid && !pv) check("rk_latency", 128'(since), 128'd4);
      if (stalled) begin
        check("stall_valid", 128'(rk_valid), 128'd1);
        check("stall_idx", 128'(round_idx), 128'(stall_round));
        check("stall_key", round_key, exp_rk[stall_round]);
      end
      pv = rk_valid;
      if (done) break;
      check("busy_hold", 128'(busy), 128'd1);
    end
    start    = 1'b0;
    rk_ready = 1'b1;
    check("done_seen", 128'(done), 128'd1);
    check("busy_at_done", 128'(busy), 128'd0);
  endtask

  initial begin
    int  cyc;
    bit  done_in_reset;
    build_sbox();
    rst_n    = 1'b0;
    start    = 1'b0;
    key_in   = '0;
    rk_ready = 1'b0;
    #12;
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_valid", 128'(rk_valid), 128'd0);
    check("rst_done", 128'(done), 128'd0);
    check("rst_key", round_key, 128'd0);
    check("rst_idx", 128'(round_idx), 128'd0);
    rst_n    = 1'b1;
    rk_ready = 1'b1;
    @(posedge clk); #1;

    // FIPS-197 key, no backpressure
    start_key(128'h2b7e151628aed2a6abf7158809cf4f3c);
    run_exp(99, 0, 1'b0, cyc);
    check("total_cycles", 128'(cyc), 128'd51);
    check("kat_fips_r1", seen[1], 128'ha0fafe1788542cb123a339392a6c7605);
    check("kat_fips_r10", seen[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // all-zero key started in the done cycle, 7-cycle stall at round 3
    check("busy_in_done", 128'(busy), 128'd0);
    start_key(128'h0);
    run_exp(3, 7, 1'b0, cyc);
    check("total_cycles_stall", 128'(cyc), 128'd58);
    check("kat_zero_r1", seen[1], 128'h62636363626363636263636362636363);
    check("kat_zero_r10", seen[10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

    // start with another key while busy must be ignored
    @(posedge clk); #1;
    check("done_pulse_end", 128'(done), 128'd0);
    start_key(128'h000102030405060708090a0b0c0d0e0f);
    run_exp(99, 0, 1'b1, cyc);
    check("total_cycles_poke", 128'(cyc), 128'd51);

    // reset while computing round 5
    @(posedge clk); #1;
    start_key(128'h3c4fcf098815f7aba6d2ae2816157e2b);
    for (int n = 0; n < 100; n++) begin
      @(posedge clk); #1;
      if (round_idx == 4'd4 && !rk_valid) break;
    end
    check("pre_reset_idx", 128'(round_idx), 128'd4);
    #3;
    rst_n = 1'b0;
    #1;
    sb_q.delete();
    check("arst_busy", 128'(busy), 128'd0);
    check("arst_valid", 128'(rk_valid), 128'd0);
    check("arst_key", round_key, 128'd0);
    check("arst_idx", 128'(round_idx), 128'd0);
    done_in_reset = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done) done_in_reset = 1'b1;
    end
    rst_n = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      if (done) done_in_reset = 1'b1;
    end
    check("no_done_after_abort", 128'(done_in_reset), 128'd0);
    start_key(128'h2b7e151628aed2a6abf7158809cf4f3c);
    run_exp(99, 0, 1'b0, cyc);
    check("kat_post_reset_r1", seen[1], 128'ha0fafe1788542cb123a339392a6c7605);

    check("sb_drained", 128'(sb_q.size()), 128'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
